// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the byte-oriented AXI-Stream FIFOs: FSM states and
// last-beat lane qualifier lookup (lane i = byte i of the 32-bit beat).
package axis_fifo_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   // rem is the packet length modulo 4; a zero remainder means a full last beat
   function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
      logic [3:0] keep;
      case (rem)
         2'd0:    keep = 4'b1111;
         2'd1:    keep = 4'b0001;
         2'd2:    keep = 4'b0011;
         default: keep = 4'b0111;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/m_axis_fifo_byte_buf.sv
// Packet storage: byte-wide write port, 32-bit word-aligned asynchronous read
// port so the transmit side can present a full beat with no stall cycle.
module byte_buf #(
   parameter int FIFO_SIZE = 1024,
   parameter int WA_W      = 8
) (
   input  logic            aclk,
   input  logic            wr_en,
   input  logic [WA_W+1:0] wr_addr,
   input  logic [7:0]      wr_data,
   input  logic [WA_W-1:0] rd_word,
   output logic [31:0]     rd_data
);

   localparam int WORDS = FIFO_SIZE / 4;

   logic [31:0] mem [WORDS];

   // Byte address splits into word index and lane; only the addressed lane changes
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_addr[WA_W+1:2]][{wr_addr[1:0], 3'b000} +: 8] <= wr_data;
      end
   end

   assign rd_data = mem[rd_word];

endmodule

// File: rtl/m_axis_fifo.sv
// Transmit FIFO: collects bytes one per cycle, then on send streams them out as
// one AXI-Stream packet of 32-bit beats with tkeep/tlast; flush aborts at any time.
module m_axis_fifo
   import axis_fifo_pkg::*;
#(
   parameter int FIFO_SIZE      = 1024,
   parameter int FIFO_ADDR_SIZE = 16
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      load_valid,
   input  logic [7:0]                load_data,
   output logic                      load_ready,
   input  logic                      send,
   input  logic                      flush,
   output logic [FIFO_ADDR_SIZE-1:0] tx_len,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               m_axis_tdata,
   output logic [3:0]                m_axis_tkeep,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready
);

   localparam int WORDS = FIFO_SIZE / 4;
   localparam int WA_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [FIFO_ADDR_SIZE-1:0] SIZE_L = FIFO_ADDR_SIZE'(FIFO_SIZE);

   state_t                    state;
   logic [FIFO_ADDR_SIZE-1:0] rd_ptr;
   logic [FIFO_ADDR_SIZE:0]   beat_end;
   logic                      load_fire;
   logic                      beat_fire;
   logic [31:0]               rd_data;
   logic [31:0]               lane_mask;

   assign load_ready    = (state == LOAD) && (tx_len < SIZE_L);
   assign load_fire     = load_valid && load_ready;
   assign busy          = (state != LOAD);
   assign done          = (state == DONE);
   assign m_axis_tvalid = (state == SEND);
   assign beat_fire     = m_axis_tvalid && m_axis_tready;

   // Widened by one bit so the end-of-beat pointer cannot wrap near capacity
   assign beat_end     = {1'b0, rd_ptr} + (FIFO_ADDR_SIZE+1)'(4);
   assign m_axis_tlast = m_axis_tvalid && (beat_end >= {1'b0, tx_len});
   assign m_axis_tkeep = !m_axis_tvalid ? 4'b0000 :
                         m_axis_tlast   ? keep_from_rem(tx_len[1:0]) : 4'b1111;
   assign lane_mask    = {{8{m_axis_tkeep[3]}}, {8{m_axis_tkeep[2]}},
                          {8{m_axis_tkeep[1]}}, {8{m_axis_tkeep[0]}}};
   assign m_axis_tdata = rd_data & lane_mask;

   byte_buf #(
      .FIFO_SIZE (FIFO_SIZE),
      .WA_W      (WA_W)
   ) u_buf (
      .aclk    (aclk),
      .wr_en   (load_fire && !flush),
      .wr_addr (tx_len[WA_W+1:0]),
      .wr_data (load_data),
      .rd_word (rd_ptr[WA_W+1:2]),
      .rd_data (rd_data)
   );

   // Reset outranks flush, flush outranks everything else including send/load
   always_ff @(posedge aclk) begin
      if (areset || flush) begin
         state  <= LOAD;
         tx_len <= '0;
         rd_ptr <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (load_fire) begin
                  tx_len <= tx_len + 1'b1;
               end
               if (send && ((tx_len != '0) || load_fire)) begin
                  state  <= SEND;
                  rd_ptr <= '0;
               end
            end
            SEND: begin
               if (beat_fire) begin
                  if (m_axis_tlast) begin
                     state  <= DONE;
                     rd_ptr <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + 3'd4;
                  end
               end
            end
            DONE: begin
               tx_len <= '0;
               state  <= LOAD;
            end
            default: begin
               state  <= LOAD;
               tx_len <= '0;
               rd_ptr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_axis_fifo.sv
// Bench for m_axis_fifo: a byte queue models the buffer and expected beats are
// derived from it with plain arithmetic; directed and random packets follow.
module tb_m_axis_fifo;

   localparam int SIZE = 64;
   localparam int AW   = 8;

   logic          aclk = 1'b0;
   logic          areset;
   logic          load_valid;
   logic [7:0]    load_data;
   logic          load_ready;
   logic          send;
   logic          flush;
   logic [AW-1:0] tx_len;
   logic          busy;
   logic          done;
   logic [31:0]   m_axis_tdata;
   logic [3:0]    m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] model_q[$];

   m_axis_fifo #(.FIFO_SIZE(SIZE), .FIFO_ADDR_SIZE(AW)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .send          (send),
      .flush         (flush),
      .tx_len        (tx_len),
      .busy          (busy),
      .done          (done),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs that must read as idle LOAD with an empty buffer
   task automatic check_idle(input string tag);
      check_output({tag, "_tx_len"}, 32'(tx_len), 32'd0);
      check_output({tag, "_load_ready"}, 32'(load_ready), 32'd1);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_done"}, 32'(done), 32'd0);
      check_output({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check_output({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
      check_output({tag, "_tkeep"}, 32'(m_axis_tkeep), 32'd0);
      check_output({tag, "_tdata"}, m_axis_tdata, 32'd0);
   endtask

   function automatic logic [31:0] exp_data(input int k);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) begin
         if (4*k + i < model_q.size()) w[8*i +: 8] = model_q[4*k + i];
      end
      return w;
   endfunction

   function automatic logic [3:0] exp_keep(input int k);
      logic [3:0] kp = '0;
      for (int i = 0; i < 4; i++) begin
         if (4*k + i < model_q.size()) kp[i] = 1'b1;
      end
      return kp;
   endfunction

   // mode 0: incrementing from base, mode 1: random bytes
   task automatic apply_stimulus(input int n, input int mode, input logic [7:0] base);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = (mode != 0) ? 8'($urandom) : 8'(base + i);
         load_valid = 1'b1;
         load_data  = d;
         check_output("load_ready", 32'(load_ready), (model_q.size() < SIZE) ? 32'd1 : 32'd0);
         tick();
         if (model_q.size() < SIZE) model_q.push_back(d);
         check_output("tx_len", 32'(tx_len), 32'(model_q.size()));
      end
      load_valid = 1'b0;
   endtask

   task automatic pulse_send();
      send = 1'b1;
      tick();
      send = 1'b0;
   endtask

   // Streams out the pending packet; stall 0 = always ready, 1 = random, 2 = 1,0,0,1
   task automatic drain(input int stall);
      int     nbeats = (model_q.size() + 3) / 4;
      int     k      = 0;
      int     cyc    = 0;
      logic   rdy;
      logic   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (k < nbeats && cyc < 4*nbeats + 40) begin
         rdy = (stall == 0) ? 1'b1 : (stall == 1) ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
         m_axis_tready = rdy;
         check_output("tvalid", 32'(m_axis_tvalid), 32'd1);
         check_output("busy", 32'(busy), 32'd1);
         check_output("tdata", m_axis_tdata, exp_data(k));
         check_output("tkeep", 32'(m_axis_tkeep), 32'(exp_keep(k)));
         check_output("tlast", 32'(m_axis_tlast), (4*k + 4 >= model_q.size()) ? 32'd1 : 32'd0);
         tick();
         if (rdy) k++;
         cyc++;
      end
      check_output("beats_sent", 32'(k), 32'(nbeats));
      m_axis_tready = 1'b0;
      check_output("done_pulse", 32'(done), 32'd1);
      check_output("done_tvalid", 32'(m_axis_tvalid), 32'd0);
      check_output("done_load_ready", 32'(load_ready), 32'd0);
      model_q.delete();
      tick();
      check_idle("after_done");
   endtask

   initial begin
      areset = 1'b1; load_valid = 1'b0; load_data = '0; send = 1'b0;
      flush = 1'b0; m_axis_tready = 1'b0;
      tick(); tick();
      areset = 1'b0;
      check_idle("reset");

      $display("[TB] eight bytes, ready high");
      apply_stimulus(8, 0, 8'h01);
      pulse_send();
      check_output("beat0_word", m_axis_tdata, 32'h04030201);
      drain(0);

      $display("[TB] five bytes, ready 1,0,0,1");
      apply_stimulus(5, 0, 8'hA0);
      pulse_send();
      check_output("beat0_a0", m_axis_tdata, 32'hA3A2A1A0);
      drain(2);

      $display("[TB] fill to capacity");
      for (int i = 0; i < SIZE + 3; i++) begin
         load_valid = 1'b1;
         load_data  = 8'($urandom);
         check_output("fill_ready", 32'(load_ready), (i < SIZE) ? 32'd1 : 32'd0);
         tick();
         if (i < SIZE) model_q.push_back(load_data);
      end
      load_valid = 1'b0;
      check_output("fill_len", 32'(tx_len), 32'(SIZE));
      pulse_send();
      drain(1);

      $display("[TB] empty send, then send with concurrent fourth byte");
      pulse_send();
      check_idle("empty_send");
      tick();
      check_idle("empty_send2");
      apply_stimulus(3, 0, 8'h31);
      load_valid = 1'b1; load_data = 8'h34; send = 1'b1;
      tick();
      model_q.push_back(8'h34);
      load_valid = 1'b0; send = 1'b0;
      check_output("concurrent_keep", 32'(m_axis_tkeep), 32'hF);
      check_output("concurrent_last", 32'(m_axis_tlast), 32'd1);
      drain(0);

      $display("[TB] flush after two beats");
      apply_stimulus(16, 1, 8'h00);
      pulse_send();
      m_axis_tready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check_output("pre_flush_data", m_axis_tdata, exp_data(k));
         check_output("pre_flush_last", 32'(m_axis_tlast), 32'd0);
         tick();
      end
      m_axis_tready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_q.delete();
      check_idle("flush");
      tick();
      check_idle("flush2");

      $display("[TB] flush beats concurrent load and send");
      apply_stimulus(2, 0, 8'h50);
      load_valid = 1'b1; load_data = 8'h77; send = 1'b1; flush = 1'b1;
      tick();
      load_valid = 1'b0; send = 1'b0; flush = 1'b0;
      model_q.delete();
      check_idle("flush_concurrent");

      $display("[TB] reset during stalled send");
      apply_stimulus(10, 1, 8'h00);
      pulse_send();
      m_axis_tready = 1'b0;
      tick();
      areset = 1'b1; flush = 1'b1;
      tick();
      areset = 1'b0; flush = 1'b0;
      model_q.delete();
      check_idle("mid_reset");
      apply_stimulus(1, 0, 8'hAA);
      apply_stimulus(1, 0, 8'hBB);
      pulse_send();
      check_output("post_reset_data", m_axis_tdata, 32'h0000BBAA);
      check_output("post_reset_keep", 32'(m_axis_tkeep), 32'h3);
      drain(0);

      $display("[TB] random packets");
      for (int r = 0; r < 12; r++) begin
         apply_stimulus($urandom_range(1, 23), 1, 8'h00);
         pulse_send();
         drain(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
